// File: rtl/read_empty.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : read_empty
// Purpose  : Read-side pointer, synchronizer and empty/level status for the
//            dual-clock asynchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module read_empty #(
  parameter int ADDRESS_SIZE        = 4,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                    rclk,
  input  logic                    rreset,
  input  logic                    rinc,
  input  logic [ADDRESS_SIZE:0]   wptr,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   rptr,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [ADDRESS_SIZE:0]   rlevel,
  output logic                    runderflow
);

  localparam logic [ADDRESS_SIZE:0] c_thresh = (ADDRESS_SIZE+1)'(ALMOST_EMPTY_THRESH);

  logic [ADDRESS_SIZE:0] r_bin;
  logic [ADDRESS_SIZE:0] r_ptr;
  logic [ADDRESS_SIZE:0] r_wq1;
  logic [ADDRESS_SIZE:0] r_wq2;
  logic [ADDRESS_SIZE:0] r_level;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic                  r_underflow;

  logic                  w_pop;
  logic [ADDRESS_SIZE:0] w_bin_next;
  logic [ADDRESS_SIZE:0] w_gray_next;
  logic [ADDRESS_SIZE:0] w_wbin_sync;
  logic [ADDRESS_SIZE:0] w_level_next;

  always_comb begin
    w_pop        = rinc & ~r_empty;
    w_bin_next   = r_bin + {{ADDRESS_SIZE{1'b0}}, w_pop};
    w_gray_next  = (w_bin_next >> 1) ^ w_bin_next;
    // Gray-to-binary: each bit is the XOR of itself and every more significant bit
    w_wbin_sync  = '0;
    for (int i = 0; i <= ADDRESS_SIZE; i++) begin
      w_wbin_sync[i] = ^(r_wq2 >> i);
    end
    w_level_next = w_wbin_sync - w_bin_next;
  end

  always_ff @(posedge rclk) begin
    if (rreset) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_wq1          <= '0;
      r_wq2          <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_wq1          <= wptr;
      r_wq2          <= r_wq1;
      r_bin          <= w_bin_next;
      r_ptr          <= w_gray_next;
      // Compare against the next pointer so popping the last entry flags empty at once
      r_empty        <= (w_gray_next == r_wq2);
      r_level        <= w_level_next;
      r_almost_empty <= (w_level_next <= c_thresh);
      r_underflow    <= r_underflow | (rinc & r_empty);
    end
  end

  assign raddr         = r_bin[ADDRESS_SIZE-1:0];
  assign rptr          = r_ptr;
  assign rempty        = r_empty;
  assign ralmost_empty = r_almost_empty;
  assign rlevel        = r_level;
  assign runderflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_read_empty.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_read_empty
// Purpose  : Self-checking bench for read_empty (table vectors + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_empty;

  logic       rclk = 1'b0;
  logic       rreset;
  logic       rinc;
  logic [4:0] wptr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rclk = ~rclk;

  read_empty #(.ADDRESS_SIZE(4), .ALMOST_EMPTY_THRESH(2)) dut (
    .rclk(rclk), .rreset(rreset), .rinc(rinc), .wptr(wptr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  typedef struct {
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       empty;
    logic       ae;
    logic [4:0] level;
    logic       uf;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       inc;
    logic [4:0] wb;
    int         lvl;
    logic       emp;
    logic       ae;
    int         ra;
    logic       uf;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[15];

  // Reference model: tracks the write pointer in binary through its own two-stage delay
  logic [4:0] m_rbin, m_w1, m_w2, m_level;
  logic       m_empty, m_ae, m_uf;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic inc, input logic [4:0] wb);
    exp_t       e;
    logic       pop;
    logic [4:0] nb;
    rreset = rst;
    rinc   = inc;
    wptr   = wb ^ (wb >> 1);
    if (rst) begin
      m_rbin = 0; m_w1 = 0; m_w2 = 0; m_level = 0;
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    end else begin
      pop     = inc && !m_empty;
      nb      = m_rbin + {4'd0, pop};
      m_uf    = m_uf | (inc & m_empty);
      m_level = m_w2 - nb;
      m_empty = (nb == m_w2);
      m_ae    = (m_level <= 5'd2);
      m_w2    = m_w1;
      m_w1    = wb;
      m_rbin  = nb;
    end
    e.raddr = m_rbin[3:0];
    e.rptr  = m_rbin ^ (m_rbin >> 1);
    e.empty = m_empty;
    e.ae    = m_ae;
    e.level = m_level;
    e.uf    = m_uf;
    exp_q.push_back(e);
    @(posedge rclk);
    #1;
    e = exp_q.pop_front();
    chk("sb_raddr", int'(raddr), int'(e.raddr));
    chk("sb_rptr", int'(rptr), int'(e.rptr));
    chk("sb_rempty", int'(rempty), int'(e.empty));
    chk("sb_ralmost_empty", int'(ralmost_empty), int'(e.ae));
    chk("sb_rlevel", int'(rlevel), int'(e.level));
    chk("sb_runderflow", int'(runderflow), int'(e.uf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] wcur;
    logic [4:0] prev_ptr;
    logic [3:0] prev_addr;
    rreset = 1'b1; rinc = 1'b0; wptr = '0;

    //         rst  inc  wb     lvl emp  ae  raddr uf
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 0, 1'b1, 1'b1, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd1, 0, 1'b1, 1'b1, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd2, 0, 1'b1, 1'b1, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd3, 1, 1'b0, 1'b1, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd3, 2, 1'b0, 1'b1, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd3, 3, 1'b0, 1'b0, 0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 2, 1'b0, 1'b1, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 5'd3, 1, 1'b0, 1'b1, 2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'd3, 0, 1'b1, 1'b1, 3, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'd3, 0, 1'b1, 1'b1, 3, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5'd5, 0, 1'b1, 1'b1, 3, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 5'd5, 0, 1'b1, 1'b1, 3, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 5'd5, 2, 1'b0, 1'b1, 3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 5'd5, 1, 1'b0, 1'b1, 4, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 5'd5, 0, 1'b1, 1'b1, 0, 1'b0};

    @(negedge rclk);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].inc, tbl[i].wb);
      chk($sformatf("tbl%0d_rlevel", i), int'(rlevel), tbl[i].lvl);
      chk($sformatf("tbl%0d_rempty", i), int'(rempty), int'(tbl[i].emp));
      chk($sformatf("tbl%0d_ralmost_empty", i), int'(ralmost_empty), int'(tbl[i].ae));
      chk($sformatf("tbl%0d_raddr", i), int'(raddr), tbl[i].ra);
      chk($sformatf("tbl%0d_runderflow", i), int'(runderflow), int'(tbl[i].uf));
    end

    // Reset held with a nonzero write pointer, then two-stage sync latency
    step(1'b1, 1'b0, 5'd4);
    step(1'b1, 1'b0, 5'd4);
    chk("rst_rlevel", int'(rlevel), 0);
    chk("rst_rptr", int'(rptr), 0);
    chk("rst_rempty", int'(rempty), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd4);
    chk("rst_release_rlevel", int'(rlevel), 4);
    chk("rst_release_rempty", int'(rempty), 0);

    // Full FIFO
    step(1'b1, 1'b0, 5'd16);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd16);
    chk("full_rlevel", int'(rlevel), 16);
    chk("full_rempty", int'(rempty), 0);
    chk("full_ralmost_empty", int'(ralmost_empty), 0);

    // Pop nine, then reset with a pending pop
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 5'd16);
    chk("midop_rlevel", int'(rlevel), 7);
    chk("midop_raddr", int'(raddr), 9);
    step(1'b1, 1'b1, 5'd16);
    chk("midrst_rptr", int'(rptr), 0);
    chk("midrst_raddr", int'(raddr), 0);
    chk("midrst_rempty", int'(rempty), 1);
    chk("midrst_rlevel", int'(rlevel), 0);
    chk("midrst_runderflow", int'(runderflow), 0);

    // Streaming writes and continuous pops across the pointer wrap
    step(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 60; i++) begin
      prev_ptr  = rptr;
      prev_addr = raddr;
      step(1'b0, 1'b1, 5'(i + 1));
      if (raddr != prev_addr)
        chk("wrap_gray_onebit", $countones(rptr ^ prev_ptr), 1);
      else
        chk("wrap_gray_hold", int'(rptr), int'(prev_ptr));
    end

    // Random traffic, write pointer never more than one depth ahead
    step(1'b1, 1'b0, 5'd0);
    wcur = 5'd0;
    for (int i = 0; i < 200; i++) begin
      if ((5'(wcur - m_rbin) < 5'd16) && ($urandom_range(0, 1) == 1)) wcur = wcur + 5'd1;
      step(1'b0, 1'($urandom_range(0, 1)), wcur);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
